// File: rtl/ethernet_rx_slot_buffer_pkg.sv
// ethernet_rx_slot_buffer_pkg: shared types, constants and helpers for the multi-slot Ethernet RX buffer
package eth_rx_pkg;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

    localparam int ETH_MIN_FRAME_BYTES = 60;
    localparam int CNT_W = 16;

    // Byte count of a low-aligned keep mask: highest set bit index + 1, zero when empty
    function automatic logic [6:0] keep_to_bytes(input logic [63:0] keep);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++)
            if (keep[i]) n = 7'(i + 1);
        return n;
    endfunction

endpackage

// File: rtl/ethernet_rx_slot_buffer_if.sv
// ethernet_rx_slot_buffer_if: AXI-Stream RX beat bus from the MAC into the slot buffer
interface ethernet_rx_slot_buffer_if #(
    parameter int recv_width_p = 64
);
    logic [recv_width_p-1:0]   tdata;
    logic [recv_width_p/8-1:0] tkeep;
    logic                      tvalid;
    logic                      tready;
    logic                      tlast;
    logic                      tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ethernet_rx_slot_buffer_ram.sv
// eth_rx_slot_ram: one-write one-read synchronous RAM holding all frame slots
module eth_rx_slot_ram #(
    parameter int width_p = 64,
    parameter int depth_p = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       we_i,
    input  logic [$clog2(depth_p)-1:0] waddr_i,
    input  logic [width_p-1:0]         wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(depth_p)-1:0] raddr_i,
    output logic [width_p-1:0]         rdata_o
);
    logic [width_p-1:0] mem_q [depth_p];
    logic [width_p-1:0] rdata_q;

    // Storage array has no reset so it can map onto block RAM
    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    // Registered read port; holds its value between strobes
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ethernet_rx_slot_buffer.sv
// ethernet_rx_slot_buffer: circular multi-slot RX frame store; ETH_RX_RUNT_DROP_EN drops good frames under 60 bytes
module ethernet_rx_slot_buffer
    import eth_rx_pkg::*;
#(
    parameter int recv_width_p     = 64,
    parameter int buf_size_p       = 2048,
    parameter int slot_p           = 4,
    parameter int drop_when_full_p = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    ethernet_rx_slot_buffer_if.slave      rx_axis,
    output logic                          ready_o,
    output logic [CNT_W-1:0]              rx_packet_size_o,
    input  logic [$clog2(buf_size_p)-1:0] buffer_read_addr_i,
    input  logic                          buffer_read_v_i,
    output logic [recv_width_p-1:0]       buffer_read_data_o,
    input  logic                          clear_buffer_i,
    output logic [$clog2(slot_p):0]       slots_used_o,
    output logic [CNT_W-1:0]              receive_count_o,
    output logic [CNT_W-1:0]              drop_count_o
);
    localparam int bytes_lp = recv_width_p / 8;
    localparam int lbpw_lp  = $clog2(bytes_lp);
    localparam int wps_lp   = buf_size_p / bytes_lp;
    localparam int depth_lp = slot_p * wps_lp;
    localparam int aw_lp    = $clog2(depth_lp);
    localparam int sw_lp    = $clog2(slot_p);
    localparam int uw_lp    = sw_lp + 1;
    localparam int pw_lp    = $clog2(wps_lp) + 1;
`ifdef ETH_RX_RUNT_DROP_EN
    localparam bit runt_drop_lp = 1'b1;
`else
    localparam bit runt_drop_lp = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [pw_lp-1:0]   word_ptr_q, word_ptr_d;
    logic [sw_lp-1:0]   wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
    logic [uw_lp-1:0]   used_q, used_d;
    logic [CNT_W-1:0]   rcv_q, rcv_d, drop_q, drop_d;
    logic               tready_q, tready_d;
    logic [CNT_W-1:0]   size_q [slot_p];
    logic               acc, free, room, clr, we, end_frame, commit, drop_inc, good;
    logic [CNT_W-1:0]   frame_size;
    logic [aw_lp-1:0]   waddr, raddr;

    assign acc        = rx_axis.tvalid & tready_q;
    assign free       = used_q < uw_lp'(slot_p);
    assign room       = word_ptr_q < pw_lp'(wps_lp);
    assign ready_o    = used_q != '0;
    assign clr        = clear_buffer_i & ready_o;
    assign frame_size = CNT_W'(word_ptr_q) * CNT_W'(bytes_lp) + CNT_W'(keep_to_bytes(64'(rx_axis.tkeep)));
    assign good       = !rx_axis.tuser && frame_size != '0 &&
                        !(runt_drop_lp && frame_size < CNT_W'(ETH_MIN_FRAME_BYTES));
    assign waddr      = aw_lp'(wr_slot_q) * aw_lp'(wps_lp) + aw_lp'(word_ptr_q);
    assign raddr      = aw_lp'(rd_slot_q) * aw_lp'(wps_lp) + aw_lp'(buffer_read_addr_i >> lbpw_lp);

    // Frame FSM: beat writes, oversize/full diversion to DROP, and commit bookkeeping
    always_comb begin
        state_d    = state_q;
        word_ptr_d = word_ptr_q;
        we         = 1'b0;
        end_frame  = 1'b0;
        drop_inc   = 1'b0;
        case (state_q)
            IDLE: if (acc) begin
                if (free) begin
                    we = 1'b1;
                    end_frame = rx_axis.tlast;
                    state_d = rx_axis.tlast ? IDLE : RECV;
                    word_ptr_d = rx_axis.tlast ? '0 : pw_lp'(1);
                end else begin
                    drop_inc = rx_axis.tlast;
                    state_d = rx_axis.tlast ? IDLE : DROP;
                end
            end
            RECV: if (acc) begin
                we = room;
                end_frame = room & rx_axis.tlast;
                drop_inc = !room & rx_axis.tlast;
                state_d = rx_axis.tlast ? IDLE : (room ? RECV : DROP);
                word_ptr_d = (rx_axis.tlast || !room) ? '0 : word_ptr_q + pw_lp'(1);
            end
            DROP: if (acc && rx_axis.tlast) begin
                drop_inc = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        commit    = end_frame & good;
        drop_inc  = drop_inc | (end_frame & !good);
        wr_slot_d = commit ? wr_slot_q + sw_lp'(1) : wr_slot_q;
        rd_slot_d = clr ? rd_slot_q + sw_lp'(1) : rd_slot_q;
        used_d    = used_q + uw_lp'(commit) - uw_lp'(clr);
        rcv_d     = rcv_q + CNT_W'(commit);
        drop_d    = (drop_inc && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
        tready_d  = state_d != IDLE || used_d < uw_lp'(slot_p) || drop_when_full_p != 0;
    end

    // State, pointers, counters and per-slot frame sizes
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state_q    <= IDLE;
            word_ptr_q <= '0;
            wr_slot_q  <= '0;
            rd_slot_q  <= '0;
            used_q     <= '0;
            rcv_q      <= '0;
            drop_q     <= '0;
            tready_q   <= 1'b0;
            for (int i = 0; i < slot_p; i++) size_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            word_ptr_q <= word_ptr_d;
            wr_slot_q  <= wr_slot_d;
            rd_slot_q  <= rd_slot_d;
            used_q     <= used_d;
            rcv_q      <= rcv_d;
            drop_q     <= drop_d;
            tready_q   <= tready_d;
            if (commit) size_q[wr_slot_q] <= frame_size;
        end

    eth_rx_slot_ram #(.width_p(recv_width_p), .depth_p(depth_lp)) u_ram (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (rx_axis.tdata),
        .re_i      (buffer_read_v_i & ready_o),
        .raddr_i   (raddr),
        .rdata_o   (buffer_read_data_o)
    );

    assign rx_axis.tready   = tready_q;
    assign rx_packet_size_o = ready_o ? size_q[rd_slot_q] : '0;
    assign slots_used_o     = used_q;
    assign receive_count_o  = rcv_q;
    assign drop_count_o     = drop_q;

`ifndef SYNTHESIS
    localparam logic [bytes_lp-1:0] keep_one_lp = 1;
    keep_contig_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        rx_axis.tvalid |-> ((rx_axis.tkeep & (rx_axis.tkeep + keep_one_lp)) == '0));
`endif
endmodule
